// File: rtl/pa_core_trap_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pa_core_trap_ctrl
// Purpose  : Trap/return sequencer and sole writer of the CSR register file.
//            On an exception it serially writes mepc, mcause, mtval and
//            mstatus, then redirects fetch to mtvec (direct or vectored).
//            On MRET it restores mstatus and redirects fetch to mepc.
//            While idle it passes execute-stage CSR writes straight through.
// Ports    : clk_i, rst_n_i            - clock, synchronous active-low reset
//            excp_req_i/cause/pc/tval  - exception request and its payload
//            mret_req_i                - MRET request
//            inst_csr_*_i              - CSR-instruction write from execute
//            csr_mtvec/mepc/mstatus_i  - current CSR values
//            csr_waddr/_vld/wdata_o    - CSR file write port
//            hold_o                    - pipeline stall
//            jump_vld_o/jump_addr_o    - one-cycle fetch redirect
// Revision : 1.0 - initial release
// ============================================================================
module pa_core_trap_ctrl #(
  parameter int DATA_W = 32,
  parameter int CSR_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              excp_req_i,
  input  logic [DATA_W-1:0] excp_cause_i,
  input  logic [DATA_W-1:0] excp_pc_i,
  input  logic [DATA_W-1:0] excp_tval_i,
  input  logic              mret_req_i,
  input  logic [CSR_W-1:0]  inst_csr_waddr_i,
  input  logic              inst_csr_waddr_vld_i,
  input  logic [DATA_W-1:0] inst_csr_wdata_i,
  input  logic [DATA_W-1:0] csr_mtvec_i,
  input  logic [DATA_W-1:0] csr_mepc_i,
  input  logic [DATA_W-1:0] csr_mstatus_i,
  output logic [CSR_W-1:0]  csr_waddr_o,
  output logic              csr_waddr_vld_o,
  output logic [DATA_W-1:0] csr_wdata_o,
  output logic              hold_o,
  output logic              jump_vld_o,
  output logic [DATA_W-1:0] jump_addr_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_MEPC   = 3'd1;
  localparam logic [2:0] S_W_MCAUSE = 3'd2;
  localparam logic [2:0] S_W_MTVAL  = 3'd3;
  localparam logic [2:0] S_W_MSTAT  = 3'd4;
  localparam logic [2:0] S_T_JUMP   = 3'd5;
  localparam logic [2:0] S_R_MSTAT  = 3'd6;
  localparam logic [2:0] S_R_JUMP   = 3'd7;

  localparam logic [CSR_W-1:0] ADDR_MSTATUS = CSR_W'('h300);
  localparam logic [CSR_W-1:0] ADDR_MEPC    = CSR_W'('h341);
  localparam logic [CSR_W-1:0] ADDR_MCAUSE  = CSR_W'('h342);
  localparam logic [CSR_W-1:0] ADDR_MTVAL   = CSR_W'('h343);

  // Clears the two low bits of an address (word alignment).
  localparam logic [DATA_W-1:0] ALIGN_MASK = ~DATA_W'(3);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] cause_q;
  logic [DATA_W-1:0] tval_q;
  logic [DATA_W-1:0] jump_addr_q;
  logic [DATA_W-1:0] mstatus_trap;
  logic [DATA_W-1:0] mstatus_ret;
  logic [DATA_W-1:0] trap_target;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic; an exception outranks MRET in the same cycle
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (excp_req_i) begin
          state_nxt = S_W_MEPC;
        end else if (mret_req_i) begin
          state_nxt = S_R_MSTAT;
        end
      end
      S_W_MEPC:   state_nxt = S_W_MCAUSE;
      S_W_MCAUSE: state_nxt = S_W_MTVAL;
      S_W_MTVAL:  state_nxt = S_W_MSTAT;
      S_W_MSTAT:  state_nxt = S_T_JUMP;
      S_T_JUMP:   state_nxt = S_IDLE;
      S_R_MSTAT:  state_nxt = S_R_JUMP;
      S_R_JUMP:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Exception payload is captured on acceptance; the pipeline may change
  // these inputs while the sequence runs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else if (state == S_IDLE && excp_req_i) begin
      pc_q    <= excp_pc_i;
      cause_q <= excp_cause_i;
      tval_q  <= excp_tval_i;
    end
  end

  // Redirect target is remembered so jump_addr_o holds between jumps.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      jump_addr_q <= '0;
    end else if (jump_vld_o) begin
      jump_addr_q <= jump_addr_o;
    end
  end

  // --------------------------------------------------------------------------
  // mstatus rewrites: trap entry saves MIE into MPIE and clears MIE;
  // return restores MIE from MPIE and sets MPIE. Both force MPP to M-mode.
  // --------------------------------------------------------------------------
  always_comb begin
    mstatus_trap        = csr_mstatus_i;
    mstatus_trap[7]     = csr_mstatus_i[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_ret         = csr_mstatus_i;
    mstatus_ret[3]      = csr_mstatus_i[7];
    mstatus_ret[7]      = 1'b1;
    mstatus_ret[12:11]  = 2'b11;
  end

  // Vectored mode only applies to interrupts; the shift drops the interrupt
  // flag and wraps modulo 2^DATA_W.
  always_comb begin
    trap_target = csr_mtvec_i & ALIGN_MASK;
    if (csr_mtvec_i[1:0] == 2'b01 && cause_q[DATA_W-1]) begin
      trap_target = trap_target + (cause_q << 2);
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    csr_waddr_o     = '0;
    csr_waddr_vld_o = 1'b0;
    csr_wdata_o     = '0;
    jump_vld_o      = 1'b0;
    jump_addr_o     = jump_addr_q;
    case (state)
      S_IDLE: begin
        // A write arriving with a request is dropped; the request wins.
        if (!excp_req_i && !mret_req_i) begin
          csr_waddr_o     = inst_csr_waddr_i;
          csr_waddr_vld_o = inst_csr_waddr_vld_i;
          csr_wdata_o     = inst_csr_wdata_i;
        end
      end
      S_W_MEPC: begin
        csr_waddr_o     = ADDR_MEPC;
        csr_waddr_vld_o = 1'b1;
        csr_wdata_o     = pc_q & ALIGN_MASK;
      end
      S_W_MCAUSE: begin
        csr_waddr_o     = ADDR_MCAUSE;
        csr_waddr_vld_o = 1'b1;
        csr_wdata_o     = cause_q;
      end
      S_W_MTVAL: begin
        csr_waddr_o     = ADDR_MTVAL;
        csr_waddr_vld_o = 1'b1;
        csr_wdata_o     = tval_q;
      end
      S_W_MSTAT: begin
        csr_waddr_o     = ADDR_MSTATUS;
        csr_waddr_vld_o = 1'b1;
        csr_wdata_o     = mstatus_trap;
      end
      S_T_JUMP: begin
        jump_vld_o  = 1'b1;
        jump_addr_o = trap_target;
      end
      S_R_MSTAT: begin
        csr_waddr_o     = ADDR_MSTATUS;
        csr_waddr_vld_o = 1'b1;
        csr_wdata_o     = mstatus_ret;
      end
      S_R_JUMP: begin
        jump_vld_o  = 1'b1;
        jump_addr_o = csr_mepc_i & ALIGN_MASK;
      end
      default: begin
        csr_waddr_vld_o = 1'b0;
      end
    endcase
  end

  // Stall is raised in the request cycle itself so the pipeline freezes
  // before the sequence begins.
  assign hold_o = (state != S_IDLE) | excp_req_i | mret_req_i;

endmodule
`default_nettype wire

// File: tb/tb_pa_core_trap_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pa_core_trap_ctrl
// Purpose  : Self-checking bench for pa_core_trap_ctrl. A transaction-level
//            model queues the expected per-cycle CSR writes and jump for each
//            accepted request; idle cycles expect pass-through.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pa_core_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        excp_req;
  logic [31:0] excp_cause;
  logic [31:0] excp_pc;
  logic [31:0] excp_tval;
  logic        mret_req;
  logic [11:0] inst_addr;
  logic        inst_vld;
  logic [31:0] inst_data;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mstatus;
  logic [11:0] csr_waddr;
  logic        csr_wvld;
  logic [31:0] csr_wdata;
  logic        hold;
  logic        jump_vld;
  logic [31:0] jump_addr;

  pa_core_trap_ctrl #(.DATA_W(32), .CSR_W(12)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .excp_req_i          (excp_req),
    .excp_cause_i        (excp_cause),
    .excp_pc_i           (excp_pc),
    .excp_tval_i         (excp_tval),
    .mret_req_i          (mret_req),
    .inst_csr_waddr_i    (inst_addr),
    .inst_csr_waddr_vld_i(inst_vld),
    .inst_csr_wdata_i    (inst_data),
    .csr_mtvec_i         (mtvec),
    .csr_mepc_i          (mepc),
    .csr_mstatus_i       (mstatus),
    .csr_waddr_o         (csr_waddr),
    .csr_waddr_vld_o     (csr_wvld),
    .csr_wdata_o         (csr_wdata),
    .hold_o              (hold),
    .jump_vld_o          (jump_vld),
    .jump_addr_o         (jump_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [11:0] addr;
    logic [31:0] data;
    logic        jv;
    logic [31:0] ja;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_jump;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic vld, input logic [11:0] addr, input logic [31:0] data,
                              input logic jv, input logic [31:0] ja);
    exp_t e;
    e.vld = vld; e.addr = addr; e.data = data; e.jv = jv; e.ja = ja;
    return e;
  endfunction

  // Architectural rules for trap entry / return, written from the mstatus
  // field definitions: MIE=bit3, MPIE=bit7, MPP=bits12:11.
  function automatic logic [31:0] ms_trap(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | (((ms >> 3) & 32'h1) << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] ms_ret(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | (((ms >> 7) & 32'h1) << 3) | 32'h0000_1880;
  endfunction

  function automatic logic [31:0] trap_tgt(input logic [31:0] tv, input logic [31:0] cause);
    logic [31:0] base;
    base = tv & ~32'h3;
    if ((tv & 32'h3) == 32'h1 && cause[31])
      return base + ((cause & 32'h7FFF_FFFF) * 4);
    return base;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    exp_t        e;
    logic        busy;
    logic [31:0] exp_ja;
    @(negedge clk);
    busy = (exp_q.size() != 0);
    if (busy) begin
      e = exp_q[0];
    end else begin
      e = mk(1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
      if (!excp_req && !mret_req) e = mk(inst_vld, inst_addr, inst_data, 1'b0, 32'h0);
    end
    exp_ja = e.jv ? e.ja : last_jump;
    chk("hold", 32'(hold), 32'(busy | excp_req | mret_req));
    chk("wvld", 32'(csr_wvld), 32'(e.vld));
    if (e.vld) begin
      chk("waddr", 32'(csr_waddr), 32'(e.addr));
      chk("wdata", csr_wdata, e.data);
    end
    chk("jvld", 32'(jump_vld), 32'(e.jv));
    chk("jaddr", jump_addr, exp_ja);
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      last_jump = 32'h0;
    end else if (busy) begin
      if (e.jv) last_jump = e.ja;
      void'(exp_q.pop_front());
    end else if (excp_req) begin
      exp_q.push_back(mk(1'b1, 12'h341, excp_pc & ~32'h3, 1'b0, 32'h0));
      exp_q.push_back(mk(1'b1, 12'h342, excp_cause, 1'b0, 32'h0));
      exp_q.push_back(mk(1'b1, 12'h343, excp_tval, 1'b0, 32'h0));
      exp_q.push_back(mk(1'b1, 12'h300, ms_trap(mstatus), 1'b0, 32'h0));
      exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, trap_tgt(mtvec, excp_cause)));
    end else if (mret_req) begin
      exp_q.push_back(mk(1'b1, 12'h300, ms_ret(mstatus), 1'b0, 32'h0));
      exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, mepc & ~32'h3));
    end
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; last_jump = 32'h0;
    rst_n = 1'b0; excp_req = 1'b1; mret_req = 1'b0;
    excp_cause = 32'h2; excp_pc = 32'h8000_0012; excp_tval = 32'hDEAD_BEEF;
    inst_addr = 12'h0; inst_vld = 1'b0; inst_data = 32'h0;
    mtvec = 32'h0000_0101; mepc = 32'h0; mstatus = 32'h0000_0008;
    @(posedge clk); #1;

    // Reset held with a pending exception: only hold reflects it.
    step(); step();

    // Direct-mode trap accepted right after reset release; request stays
    // high through the writes and must not restart the sequence.
    rst_n = 1'b1;
    step();
    excp_pc = 32'h1111_1111; excp_cause = 32'h5; excp_tval = 32'h0;
    repeat (4) step();
    excp_req = 1'b0;
    step();
    chk("direct_target", jump_addr, 32'h0000_0100);
    step();

    // Vectored interrupt.
    mtvec = 32'h0000_1001; excp_cause = 32'h8000_0007; excp_req = 1'b1;
    step();
    excp_req = 1'b0;
    repeat (5) step();
    chk("vector_target", jump_addr, 32'h0000_101C);

    // MRET.
    mstatus = 32'h0000_1880; mepc = 32'h8000_0010; mret_req = 1'b1;
    step();
    mret_req = 1'b0;
    repeat (2) step();
    chk("mret_target", jump_addr, 32'h8000_0010);

    // Exception, MRET and a CSR write all at once: exception only.
    excp_req = 1'b1; mret_req = 1'b1; inst_vld = 1'b1; inst_addr = 12'h340; inst_data = 32'h55AA_55AA;
    step();
    excp_req = 1'b0; mret_req = 1'b0;
    repeat (5) step();
    inst_vld = 1'b0;

    // Pass-through.
    inst_vld = 1'b1; inst_addr = 12'h305; inst_data = 32'h0000_1234;
    step();
    inst_vld = 1'b0;

    // Reset during W_MCAUSE abandons the sequence.
    excp_req = 1'b1;
    step();
    excp_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("reset_clears_target", jump_addr, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) begin
        mtvec   = $urandom();
        if ($urandom_range(0, 1) == 0) mtvec = (mtvec & ~32'h3) | 32'h1;
        mstatus = $urandom();
        mepc    = $urandom();
      end
      excp_req   = ($urandom_range(0, 5) == 0);
      mret_req   = ($urandom_range(0, 6) == 0);
      excp_cause = $urandom();
      excp_pc    = $urandom();
      excp_tval  = $urandom();
      inst_vld   = ($urandom_range(0, 1) == 0);
      inst_addr  = 12'($urandom());
      inst_data  = $urandom();
      rst_n      = ($urandom_range(0, 39) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pa_core_trap_ctrl.md
Name: pa_core_trap_ctrl

Overview:
- Trap/return sequencer that drives the CSR register file's single write port (csr_waddr/csr_waddr_vld/csr_wdata).
- On a synchronous exception it serially writes mepc, mcause, mtval and mstatus, then redirects fetch to mtvec.
- On MRET it restores mstatus and redirects fetch to mepc.
- In idle it passes CSR-instruction writes from execute straight through, so it is the sole writer of the CSR file.

Parameters:
DATA_W, 32, data/CSR value width (matches DATA_BUS_WIDTH)
CSR_W, 12, CSR address width (matches CSR_BUS_WIDTH)

Ports:
clk_i  input  1  core clock
rst_n_i  input  1  reset, synchronous, active-low
excp_req_i  input  1  exception request (level; held by pipeline until hold_o drops)
excp_cause_i  input  DATA_W  mcause value ([31]=interrupt flag)
excp_pc_i  input  DATA_W  PC of faulting instruction
excp_tval_i  input  DATA_W  mtval value
mret_req_i  input  1  MRET request
inst_csr_waddr_i  input  CSR_W  CSR-instruction write address
inst_csr_waddr_vld_i  input  1  CSR-instruction write valid
inst_csr_wdata_i  input  DATA_W  CSR-instruction write data
csr_mtvec_i  input  DATA_W  current mtvec from CSR file
csr_mepc_i  input  DATA_W  current mepc from CSR file
csr_mstatus_i  input  DATA_W  current mstatus from CSR file
csr_waddr_o  output  CSR_W  CSR write address
csr_waddr_vld_o  output  1  CSR write strobe
csr_wdata_o  output  DATA_W  CSR write data
hold_o  output  1  pipeline stall
jump_vld_o  output  1  one-cycle fetch redirect pulse
jump_addr_o  output  DATA_W  redirect target

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_n_i.
  - Reset forces state IDLE and clears latched cause/pc/tval.
  - All registered outputs reset to 0 (csr_waddr_vld_o=0, jump_vld_o=0, jump_addr_o=0).
  - Reset mid-sequence abandons the sequence; no further CSR writes or jumps.
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, T_JUMP, R_MSTAT, R_JUMP.
- IDLE:
  - If excp_req_i=1: accept. Latch pc/cause/tval and go to W_MEPC. excp_req_i has priority over mret_req_i and over any inst write in the same cycle; that inst write is dropped.
  - Else if mret_req_i=1: go to R_MSTAT. An inst write in the same cycle is dropped.
  - Else: pass through combinationally: csr_waddr_o=inst_csr_waddr_i, csr_waddr_vld_o=inst_csr_waddr_vld_i, csr_wdata_o=inst_csr_wdata_i.
- Outside IDLE:
  - Inst writes and new requests are ignored.
  - csr_waddr_o/csr_wdata_o are driven only by the sequence; csr_waddr_vld_o=1 only in W_* and R_MSTAT.
- Trap sequence, one write per cycle:
  - W_MEPC: addr 0x341, data pc with [1:0] forced 0.
  - W_MCAUSE: addr 0x342, data cause.
  - W_MTVAL: addr 0x343, data tval.
  - W_MSTAT: addr 0x300, data = csr_mstatus_i with [7]=csr_mstatus_i[3], [3]=0, [12:11]=2'b11.
  - T_JUMP: jump_vld_o=1, then back to IDLE. Target:
    - mtvec[1:0]==2'b01 and cause[31]=1: jump_addr_o={mtvec[31:2],2'b00} + (cause[30:0]<<2), 32-bit wrap.
    - Otherwise: {mtvec[31:2],2'b00}.
  - Total latency: accept cycle + 4 write cycles; jump on the 5th cycle after accept.
- MRET sequence:
  - R_MSTAT: addr 0x300, data = csr_mstatus_i with [3]=csr_mstatus_i[7], [7]=1, [12:11]=2'b11.
  - R_JUMP: jump_vld_o=1, jump_addr_o={csr_mepc_i[31:2],2'b00}, then back to IDLE.
- hold_o:
  - 1 when state!=IDLE, or in IDLE when excp_req_i or mret_req_i is 1 (combinational).
  - 0 on the cycle after T_JUMP/R_JUMP returns to IDLE.
- Outside the jump cycles, jump_vld_o=0 and jump_addr_o holds its last value.
- A request held high in the IDLE cycle after a jump is treated as a new request; the pipeline must flush before then.

Test Plan:
- Reset: rst_n_i=0 for 2 cycles with excp_req_i=1 → csr_waddr_vld_o=0, jump_vld_o=0, hold_o=1 only combinationally; after release, a trap sequence starts.
- Trap, direct mode: mtvec=0x0000_0101, mstatus=0x0000_0008, pc=0x8000_0012, cause=2, tval=0xDEAD_BEEF → writes 0x341←0x8000_0010, 0x342←2, 0x343←0xDEAD_BEEF, 0x300←0x0000_1880 on cycles 1–4; jump to 0x0000_0100 on cycle 5; hold_o high cycles 0–5.
- Vectored interrupt: mtvec=0x0000_1001, cause=0x8000_0007 → jump_addr_o=0x0000_101C.
- MRET: mstatus=0x0000_1880, mepc=0x8000_0010 → write 0x300←0x0000_1888 on cycle 1; jump to 0x8000_0010 on cycle 2.
- Simultaneous excp_req_i, mret_req_i and inst write to 0x340 in IDLE → only the trap sequence runs; no 0x340 write occurs; mret is ignored.
- Pass-through in IDLE: inst write 0x305←0x1234 → same-cycle csr_waddr_vld_o=1, addr 0x305, data 0x1234; reset asserted during W_MCAUSE → no W_MTVAL write, no jump.
